// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter that shares one system memory bus between NMASTERS
//   requesters (caches, debug/DMA). A grant is held until the owner drops its
//   request, then one dead RELEASE cycle passes before the next arbitration.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   m_req   [N]        per-master request
//   m_ack   [N]        registered one-hot grant (zero when nobody owns the bus)
//   m_addr  [32N]      master i address in bits [32i+31:32i]
//   m_rd/m_wr [N]      per-master read/write strobes
//   m_wdata [32N]      per-master write data
//   m_ready [N]        bus_ready steered to the granted master
//   m_rdata [32]       bus_data broadcast to all masters
//   bus_addr/bus_rd/bus_wr/bus_wdata   shared bus, driven by the owner only
//   bus_data, bus_ready                memory read data and beat completion
//   grant_idx [IDXW]   current owner index, 0 when idle
//   overrun            sticky: a grant outlasted HOLD_LIMIT while others waited
module bus_arbiter #(
  parameter int NMASTERS   = 4,
  parameter int IDXW       = 2,
  parameter int HOLD_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NMASTERS-1:0]      m_req,
  output logic [NMASTERS-1:0]      m_ack,
  input  logic [32*NMASTERS-1:0]   m_addr,
  input  logic [NMASTERS-1:0]      m_rd,
  input  logic [NMASTERS-1:0]      m_wr,
  input  logic [32*NMASTERS-1:0]   m_wdata,
  output logic [NMASTERS-1:0]      m_ready,
  output logic [31:0]              m_rdata,
  output logic [31:0]              bus_addr,
  output logic                     bus_rd,
  output logic                     bus_wr,
  output logic [31:0]              bus_wdata,
  input  logic [31:0]              bus_data,
  input  logic                     bus_ready,
  output logic [IDXW-1:0]          grant_idx,
  output logic                     overrun
);

  localparam int              HW       = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_LIMIT);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NMASTERS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state;
  logic [IDXW-1:0] rr_last;
  logic [IDXW-1:0] winner;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_nxt;
  logic            owner_req;
  logic            others_req;

  logic [31:0]     addr_arr  [NMASTERS];
  logic [31:0]     wdata_arr [NMASTERS];

  // Search begins one past the previous winner and wraps, so the last owner
  // is always considered last. Scanning from the far end lets the nearest
  // requester overwrite the result.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NMASTERS-1:0] req,
                                              input logic [IDXW-1:0]     last);
    logic [IDXW-1:0] pick;
    logic [31:0]     cand;
    pick = '0;
    for (int k = NMASTERS; k >= 1; k--) begin
      cand = (32'(last) + 32'(k)) % 32'(NMASTERS);
      if (req[cand[IDXW-1:0]]) pick = cand[IDXW-1:0];
    end
    return pick;
  endfunction

  assign winner     = rr_pick(m_req, rr_last);
  assign owner_req  = |(m_req & m_ack);
  assign others_req = |(m_req & ~m_ack);
  assign hold_nxt   = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_ack     <= '0;
      grant_idx <= '0;
      rr_last   <= LAST_RST;
      hold_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_req) begin
            state     <= GRANT;
            m_ack     <= NMASTERS'(1) << winner;
            grant_idx <= winner;
            rr_last   <= winner;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state     <= RELEASE;
            m_ack     <= '0;
            grant_idx <= '0;
          end else begin
            hold_cnt <= hold_nxt;
            // The grant is never revoked; a long hold is only flagged.
            if ((HOLD_LIMIT != 0) && (hold_nxt == HOLD_MAX) && others_req)
              overrun <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NMASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[32*i +: 32];
    assign wdata_arr[i] = m_wdata[32*i +: 32];
  end

  // Bus side follows the registered grant; strobes from non-owners never
  // reach the bus.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    if (state == GRANT) begin
      bus_addr  = addr_arr[grant_idx];
      bus_wdata = wdata_arr[grant_idx];
      bus_rd    = m_rd[grant_idx];
      bus_wr    = m_wr[grant_idx];
    end
  end

  assign m_ready = {NMASTERS{bus_ready}} & m_ack;
  assign m_rdata = bus_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter (4 masters, HOLD_LIMIT=16). Expected grant
//   order is queued when requests are driven and popped by a monitor when a
//   new grant appears.
module tb_bus_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    m_req;
  logic [3:0]    m_ack;
  logic [127:0]  m_addr;
  logic [3:0]    m_rd;
  logic [3:0]    m_wr;
  logic [127:0]  m_wdata;
  logic [3:0]    m_ready;
  logic [31:0]   m_rdata;
  logic [31:0]   bus_addr;
  logic          bus_rd;
  logic          bus_wr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_data;
  logic          bus_ready;
  logic [1:0]    grant_idx;
  logic          overrun;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            exp_q[$];
  logic          gap_chk = 1'b0;

  bus_arbiter #(.NMASTERS(4), .IDXW(2), .HOLD_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr),
    .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_ready(m_ready),
    .m_rdata(m_rdata), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_data(bus_data), .bus_ready(bus_ready),
    .grant_idx(grant_idx), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    int cnt;
    cnt = 0;
    while (m_ack == 4'b0 && cnt < 20) begin
      tick(1);
      cnt++;
    end
    chk({tag, "_timeout"}, 32'(cnt >= 20), 32'd0);
  endtask

  // Scoreboard monitor: every rising grant must match the next queued index;
  // during the rotation test the ack-low gap before it must be 2 cycles.
  int   low_cnt  = 0;
  logic [3:0] prev_ack = 4'b0;
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      low_cnt  = 0;
      prev_ack = 4'b0;
    end else begin
      if (m_ack != 4'b0 && prev_ack == 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_grant", 32'(m_ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant", 32'(m_ack), 32'd1 << e);
        end
        if (gap_chk) chk("sb_gap", 32'(low_cnt), 32'd2);
        low_cnt = 0;
      end else if (m_ack == 4'b0) begin
        low_cnt++;
      end
      prev_ack = m_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst_n = 1'b0; m_req = '0; m_addr = '0; m_rd = '0; m_wr = '0;
    m_wdata = '0; bus_data = '0; bus_ready = 1'b0;

    // Reset held for 3 cycles
    tick(3);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_rdwr", 32'({bus_rd, bus_wr}), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single request, master 0
    m_req = 4'b0001; m_addr[31:0] = 32'h0000_1040; m_rd[0] = 1'b1;
    exp_q.push_back(0);
    #1;
    chk("idle_no_strobe", 32'(bus_rd), 32'd0);
    tick(1);
    chk("single_ack", 32'(m_ack), 32'b0001);
    chk("single_addr", bus_addr, 32'h0000_1040);
    chk("single_rd", 32'(bus_rd), 32'd1);
    m_req = 4'b0000; m_rd = '0;
    tick(1);
    chk("single_drop_ack", 32'(m_ack), 32'd0);
    chk("single_drop_addr", bus_addr, 32'd0);
    // Re-request during RELEASE: IDLE comes first, grant one edge later
    m_req = 4'b0001; m_rd[0] = 1'b1;
    exp_q.push_back(0);
    tick(1);
    chk("release_gap_ack", 32'(m_ack), 32'd0);
    tick(1);
    chk("regrant_ack", 32'(m_ack), 32'b0001);

    // Asynchronous reset in the middle of a grant
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(m_ack), 32'd0);
    chk("async_rst_rd", 32'(bus_rd), 32'd0);
    chk("async_rst_idx", 32'(grant_idx), 32'd0);
    m_req = '0; m_rd = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Rotation with all masters requesting, each holding 3 cycles
    m_req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      wait_ack("rr");
      chk("rr_idx", 32'(grant_idx), 32'(g));
      tick(2);
      if (k == 0) gap_chk = 1'b1;
      if (k == 4) gap_chk = 1'b0;
      m_req[g] = 1'b0;
      tick(1);
      if (k < 4) m_req[g] = 1'b1;
    end
    m_req = '0;
    tick(3);

    // Fairness: re-requesting owner goes to the back of the line
    m_req = 4'b0100; exp_q.push_back(2);
    wait_ack("fair2");
    chk("fair_first", 32'(grant_idx), 32'd2);
    m_req = 4'b0101;
    tick(3);
    chk("no_preempt", 32'(m_ack), 32'b0100);
    m_req = 4'b0001;
    tick(1);
    m_req = 4'b0101; exp_q.push_back(0); exp_q.push_back(2);
    wait_ack("fair0");
    chk("fair_after_2", 32'(grant_idx), 32'd0);
    m_req = 4'b1100;
    tick(1);
    wait_ack("fair2b");
    chk("fair_after_0", 32'(grant_idx), 32'd2);
    m_req = 4'b1000; exp_q.push_back(3);
    tick(1);
    wait_ack("fair3");
    chk("fair_after_2b", 32'(grant_idx), 32'd3);
    m_req = '0;
    tick(3);

    // Data routing to master 1, master 2 strobing without a grant
    m_req = 4'b0010; exp_q.push_back(1);
    m_addr[63:32] = 32'h2000_0080; m_wr[1] = 1'b1; m_wdata[63:32] = 32'hDEAD_BEEF;
    m_rd[2] = 1'b1;
    wait_ack("data");
    chk("data_idx", 32'(grant_idx), 32'd1);
    chk("data_addr", bus_addr, 32'h2000_0080);
    chk("data_wr", 32'(bus_wr), 32'd1);
    chk("data_rd_ungranted", 32'(bus_rd), 32'd0);
    chk("data_wdata", bus_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      bus_ready = 1'b1; bus_data = 32'hA0 + 32'(i);
      #1;
      chk("data_ready", 32'(m_ready), 32'b0010);
      chk("data_rdata", m_rdata, 32'hA0 + 32'(i));
      tick(1);
      bus_ready = 1'b0;
      #1;
      chk("data_ready_low", 32'(m_ready), 32'd0);
      tick(1);
    end
    m_req = '0; m_wr = '0; m_rd = '0;
    tick(2);
    bus_ready = 1'b1;
    #1;
    chk("ready_no_grant", 32'(m_ready), 32'd0);
    bus_ready = 1'b0;
    tick(2);

    // Long hold without competition: no overrun
    m_req = 4'b0001; exp_q.push_back(0);
    wait_ack("hold_alone");
    tick(20);
    chk("hold_alone_ovr", 32'(overrun), 32'd0);
    m_req = '0;
    tick(3);

    // Long hold with master 3 waiting: overrun on the 16th grant cycle
    m_req = 4'b0001; exp_q.push_back(0);
    wait_ack("hold_comp");
    m_req[3] = 1'b1; exp_q.push_back(3);
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      chk("ovr_cycle", 32'(overrun), 32'(j >= 16));
    end
    m_req[0] = 1'b0;
    tick(1);
    chk("ovr_release_ack", 32'(m_ack), 32'd0);
    chk("ovr_sticky_rel", 32'(overrun), 32'd1);
    wait_ack("ovr_next");
    chk("ovr_next_idx", 32'(grant_idx), 32'd3);
    m_req = '0;
    tick(3);
    chk("ovr_sticky_idle", 32'(overrun), 32'd1);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
